// File: rtl/vga_fb_reader.sv
// vga_fb_reader: 640x480@60 VGA timing generator and framebuffer reader.
// Walks the frame with hcnt/vcnt and issues one sequential read address per
// active pixel. The returned byte is shown as 4-bit grayscale. Sync and blank
// flags are delayed to match the fixed read latency of the framebuffer port.
// Read port contract: raddr is presented every clock and is never stalled.
// rdata belongs to the raddr that was presented RD_LAT clocks earlier.
module vga_fb_reader #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int RD_LAT    = 1
) (
    input  logic        clk25,
    input  logic        rst_n,
    input  logic [7:0]  rdata,
    output logic [18:0] raddr,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    typedef struct packed {
        logic active;
        logic hs_n;
        logic vs_n;
        logic fs;
    } flags_t;

    localparam flags_t FLAGS_RST = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0};

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [18:0]   raddr_q, raddr_d;
    flags_t        stage0;
    flags_t        pipe_q [RD_LAT];
    flags_t        pipe_d [RD_LAT];
    logic [3:0]    pix_q, pix_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          fs_q, fs_d;
    logic          frame_end;

    // The low nibble of each pixel byte is dropped by the grayscale conversion.
    logic unused_rdata_lo;
    assign unused_rdata_lo = ^rdata[3:0];

    // Counter and address advance; raddr tracks vcnt*H_VISIBLE+hcnt by increments.
    always_comb begin
        frame_end = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
        hcnt_d    = (hcnt_q == H_LAST) ? '0 : hcnt_q + 1'b1;
        vcnt_d    = vcnt_q;
        if (hcnt_q == H_LAST) begin
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end
        stage0.active = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
        stage0.hs_n   = !((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
        stage0.vs_n   = !((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));
        stage0.fs     = (hcnt_q == '0) && (vcnt_q == '0);
        raddr_d = raddr_q;
        if (frame_end) begin
            raddr_d = '0;
        end else if (stage0.active) begin
            raddr_d = raddr_q + 19'd1;
        end
    end

    // Flag delay line, then grayscale conversion in the output register.
    always_comb begin
        pipe_d[0] = stage0;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        pix_d = pipe_q[RD_LAT-1].active ? rdata[7:4] : 4'h0;
        hs_d  = pipe_q[RD_LAT-1].hs_n;
        vs_d  = pipe_q[RD_LAT-1].vs_n;
        fs_d  = pipe_q[RD_LAT-1].fs;
    end

    // All state registers with synchronous active-low reset.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            raddr_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= FLAGS_RST;
            end
            pix_q <= 4'h0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            fs_q  <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            raddr_q <= raddr_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            pix_q <= pix_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            fs_q  <= fs_d;
        end
    end

    assign raddr       = raddr_q;
    assign vga_r       = pix_q;
    assign vga_g       = pix_q;
    assign vga_b       = pix_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign frame_start = fs_q;

endmodule
